// File: rtl/ex_wb_result_buffer.sv
// ex_wb_result_buffer
// Two-entry in-order result buffer between the ALU and writeback.
// - Captures {data, tag, func} on every accepted execute result.
// - in_ready is decoded from registered occupancy only. This keeps
//   writeback back-pressure from forming a combinational path into execute.
// - Provides a combinational forwarding lookup for decode over the entries
//   currently held. The youngest matching entry wins.
// Optional build macro: ALU_FLAGS_EN
// - When defined, each entry also carries zero/neg flags taken from the data
//   at push time. The flags are exposed as out_zero/out_neg.
module ex_wb_result_buffer #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int FUNC_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [FUNC_W-1:0] in_func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [FUNC_W-1:0] out_func,
    output logic [1:0]        count,
    input  logic [TAG_W-1:0]  fwd_tag,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`ifdef ALU_FLAGS_EN
    ,
    output logic              out_zero,
    output logic              out_neg
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [FUNC_W-1:0] func;
`ifdef ALU_FLAGS_EN
        logic              zero;
        logic              neg;
`endif
    } entry_t;

    entry_t     head_q, tail_q, in_ent;
    logic [1:0] count_q;
    logic       push, pop;

    // Pack the incoming ALU result into an entry.
    // When enabled, the flags are computed here at push time.
    always_comb begin
        in_ent      = '0;
        in_ent.data = in_data;
        in_ent.tag  = in_tag;
        in_ent.func = in_func;
`ifdef ALU_FLAGS_EN
        in_ent.zero = (in_data == '0);
        in_ent.neg  = in_data[DATA_W-1];
`endif
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy: flush overrides any push/pop seen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: if (push) count_q <= 2'd1;
                2'd1: begin
                    if (push && !pop)      count_q <= 2'd2;
                    else if (pop && !push) count_q <= 2'd0;
                end
                2'd2: if (pop) count_q <= 2'd1;
                default: count_q <= 2'd0;
            endcase
        end
    end

    // Head entry.
    // - Filled directly from the ALU when the buffer is empty, or when the
    //   sole entry leaves in the same cycle.
    // - Otherwise, on a pop from full, the tail moves up into the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
        end else if (!flush) begin
            if (count_q == 2'd2 && pop)
                head_q <= tail_q;
            else if (push && (count_q == 2'd0 || pop))
                head_q <= in_ent;
        end
    end

    // Tail entry: only written when a second result arrives while the head stays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_q <= '0;
        end else if (!flush && push && count_q == 2'd1 && !pop) begin
            tail_q <= in_ent;
        end
    end

    assign out_data = head_q.data;
    assign out_tag  = head_q.tag;
    assign out_func = head_q.func;
    assign count    = count_q;
`ifdef ALU_FLAGS_EN
    assign out_zero = head_q.zero;
    assign out_neg  = head_q.neg;
`endif

    // Forwarding lookup.
    // - The youngest (tail) match is checked first.
    // - Tag 0 never hits, because register 0 always reads as zero.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_tag != '0) begin
            if (count_q == 2'd2 && tail_q.tag == fwd_tag) begin
                fwd_hit  = 1'b1;
                fwd_data = tail_q.data;
            end else if (count_q != 2'd0 && head_q.tag == fwd_tag) begin
                fwd_hit  = 1'b1;
                fwd_data = head_q.data;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_result_buffer.sv
// Bench for ex_wb_result_buffer.
// - The model is a queue of in-flight results and a log of results consumed
//   by writeback.
// - Outputs are compared against the model on every falling edge.
// - Directed sequences add literal expectations.
module tb_ex_wb_result_buffer;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [TW-1:0] in_tag = '0;
    logic [FW-1:0] in_func = '0;
    logic [TW-1:0] fwd_tag = '0;
    logic          in_ready, out_valid, fwd_hit;
    logic [DW-1:0] out_data, fwd_data;
    logic [TW-1:0] out_tag;
    logic [FW-1:0] out_func;
    logic [1:0]    count;
`ifdef ALU_FLAGS_EN
    logic          out_zero, out_neg;
`endif

    ex_wb_result_buffer #(.DATA_W(DW), .TAG_W(TW), .FUNC_W(FW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .in_func(in_func),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_func(out_func),
        .count(count), .fwd_tag(fwd_tag), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`ifdef ALU_FLAGS_EN
        , .out_zero(out_zero), .out_neg(out_neg)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic [FW-1:0] f;
    } ent_t;

    ent_t mq[$];   // in-flight results, oldest first
    ent_t wb[$];   // results consumed by writeback, in order

    // Model: a bounded FIFO of depth 2 sampled at each rising edge.
    always @(posedge clk or posedge rst) begin
        bit   pu, po;
        ent_t e;
        if (rst) begin
            mq.delete();
        end else begin
            pu = in_valid && (mq.size() < 2);
            po = out_ready && (mq.size() > 0);
            if (po) wb.push_back(mq[0]);
            if (flush) begin
                mq.delete();
            end else begin
                if (po) void'(mq.pop_front());
                if (pu) begin
                    e.d = in_data;
                    e.t = in_tag;
                    e.f = in_func;
                    mq.push_back(e);
                end
            end
        end
    end

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        bit            hit;
        logic [DW-1:0] fd;
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() != 2));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(mq[0].d));
            chk("out_tag", 64'(out_tag), 64'(mq[0].t));
            chk("out_func", 64'(out_func), 64'(mq[0].f));
`ifdef ALU_FLAGS_EN
            chk("out_zero", 64'(out_zero), 64'(mq[0].d == 0));
            chk("out_neg", 64'(out_neg), 64'(mq[0].d[DW-1]));
`endif
        end
        hit = 1'b0;
        fd  = '0;
        if (fwd_tag != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].t == fwd_tag) begin
                    hit = 1'b1;
                    fd  = mq[i].d;
                end
            end
        end
        chk("fwd_hit", 64'(fwd_hit), 64'(hit));
        chk("fwd_data", 64'(fwd_data), 64'(fd));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input bit r, input bit fl,
                       input logic [DW-1:0] d, input logic [TW-1:0] t,
                       input logic [FW-1:0] f, input logic [TW-1:0] ft);
        in_valid  = v;
        out_ready = r;
        flush     = fl;
        in_data   = d;
        in_tag    = t;
        in_func   = f;
        fwd_tag   = ft;
    endtask

    initial begin
        // Reset state.
        fwd_tag = 5'd3;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_func", 64'(out_func), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_neg", 64'(out_neg), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Two pushes with writeback stalled, then drain in order.
        cyc();
        drv(1, 0, 0, 32'h0000_0005, 5'd3, 6'd1, 5'd0);
        cyc();
        drv(1, 0, 0, 32'hFFFF_FFFF, 5'd4, 6'd2, 5'd0);
        cyc();
        drv(0, 1, 0, 32'h0, 5'd0, 6'd0, 5'd0);
        @(negedge clk);
        chk("full_count", 64'(count), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_data", 64'(out_data), 64'h5);
        cyc();
        @(negedge clk);
        chk("drain1_out_data", 64'(out_data), 64'hFFFF_FFFF);
        chk("drain1_out_tag", 64'(out_tag), 64'd4);
        cyc();
        drv(0, 0, 0, 32'h0, 5'd0, 6'd0, 5'd0);
        @(negedge clk);
        chk("drain_count", 64'(count), 64'd0);
        chk("wb_n", 64'(wb.size()), 64'd2);
        if (wb.size() == 2) begin
            chk("wb0", 64'(wb[0].d), 64'h5);
            chk("wb1", 64'(wb[1].d), 64'hFFFF_FFFF);
        end

        // Simultaneous push and pop at count 1.
        cyc();
        drv(1, 0, 0, 32'hAA, 5'd1, 6'd3, 5'd0);
        cyc();
        drv(1, 1, 0, 32'h10, 5'd7, 6'd4, 5'd0);
        cyc();
        drv(0, 0, 0, 32'h0, 5'd0, 6'd0, 5'd0);
        @(negedge clk);
        chk("pp_count", 64'(count), 64'd1);
        chk("pp_out_data", 64'(out_data), 64'h10);
        chk("pp_out_tag", 64'(out_tag), 64'd7);

        // Flush wins over a same-cycle push.
        cyc();
        drv(1, 0, 1, 32'h33, 5'd5, 6'd5, 5'd0);
        cyc();
        drv(0, 0, 0, 32'h0, 5'd0, 6'd0, 5'd0);
        @(negedge clk);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);

        // Forwarding: youngest match wins, tag 0 never hits, a miss returns 0.
        cyc();
        drv(1, 0, 0, 32'h11, 5'd3, 6'd6, 5'd0);
        cyc();
        drv(1, 0, 0, 32'h22, 5'd3, 6'd7, 5'd3);
        cyc();
        drv(0, 0, 0, 32'h0, 5'd0, 6'd0, 5'd3);
        @(negedge clk);
        chk("fwd3_hit", 64'(fwd_hit), 64'd1);
        chk("fwd3_data", 64'(fwd_data), 64'h22);
        fwd_tag = 5'd0;
        #1;
        chk("fwd0_hit", 64'(fwd_hit), 64'd0);
        chk("fwd0_data", 64'(fwd_data), 64'd0);
        fwd_tag = 5'd9;
        #1;
        chk("fwd9_hit", 64'(fwd_hit), 64'd0);
        chk("fwd9_data", 64'(fwd_data), 64'd0);

        // Asynchronous reset with the buffer full.
        cyc();
        chk("pre_rst_count", 64'(count), 64'd2);
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors; the per-cycle compare judges each one.
        cyc(); drv(1, 0, 0, 32'h0000_0100, 5'd2, 6'd10, 5'd2);
        cyc(); drv(1, 0, 0, 32'h0000_0200, 5'd6, 6'd11, 5'd2);
        cyc(); drv(1, 0, 0, 32'h0000_0300, 5'd8, 6'd12, 5'd6);
        cyc(); drv(1, 1, 0, 32'h0000_0400, 5'd2, 6'd13, 5'd2);
        cyc(); drv(1, 1, 0, 32'h0000_0500, 5'd9, 6'd14, 5'd2);
        cyc(); drv(1, 1, 0, 32'h0000_0600, 5'd2, 6'd15, 5'd2);
        cyc(); drv(0, 1, 0, 32'h0,         5'd0, 6'd0,  5'd9);
        cyc(); drv(0, 1, 0, 32'h0,         5'd0, 6'd0,  5'd2);
        cyc(); drv(1, 1, 0, 32'hDEAD_BEEF, 5'd31, 6'd63, 5'd31);
        cyc(); drv(1, 0, 0, 32'h1234_5678, 5'd1, 6'd1,  5'd31);
        cyc(); drv(0, 1, 1, 32'h0,         5'd0, 6'd0,  5'd1);
        cyc(); drv(1, 1, 0, 32'h7,         5'd4, 6'd2,  5'd4);
        cyc(); drv(0, 1, 0, 32'h0,         5'd0, 6'd0,  5'd4);
        cyc(); drv(0, 0, 0, 32'h0,         5'd0, 6'd0,  5'd0);
        @(negedge clk);
        chk("vec_end_count", 64'(count), 64'd0);

`ifdef ALU_FLAGS_EN
        // Zero and negative flags follow the head entry.
        cyc(); drv(1, 0, 0, 32'h0000_0000, 5'd1, 6'd0, 5'd0);
        cyc(); drv(1, 0, 0, 32'h8000_0000, 5'd2, 6'd0, 5'd0);
        cyc(); drv(0, 0, 0, 32'h0, 5'd0, 6'd0, 5'd0);
        @(negedge clk);
        chk("flag0_zero", 64'(out_zero), 64'd1);
        chk("flag0_neg", 64'(out_neg), 64'd0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        chk("flag1_zero", 64'(out_zero), 64'd0);
        chk("flag1_neg", 64'(out_neg), 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
